// File: rtl/shift_ser_pkg.sv
// ============================================================================
// shift_ser_pkg : shared state encoding and line levels for the serializer
// Revision      : 1.0
// ============================================================================
`default_nettype none

package shift_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_word_serializer_bit_tick_gen.sv
// ============================================================================
// bit_tick_gen : counts DIV clock cycles per serial bit and flags the bit end
// Revision     : 1.0
// ============================================================================
`default_nettype none

module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_end,
  output logic o_pre_end
);

  localparam int TW = $clog2(DIV + 1);

  logic [TW-1:0] r_tick;
  logic          w_last;

  assign w_last    = (r_tick == TW'(DIV - 1));
  assign o_bit_end = i_en && w_last;

  // o_pre_end: the next enabled cycle is the final cycle of the current bit
  generate
    if (DIV == 1) begin : g_div_one
      assign o_pre_end = i_en;
    end else begin : g_div_multi
      assign o_pre_end = i_en && (r_tick == TW'(DIV - 2));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_tick <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_word_serializer.sv
// ============================================================================
// shift_word_serializer : sends a parallel word as start + data + stop frame
// Revision              : 1.0
// ============================================================================
`default_nettype none

module shift_word_serializer
  import shift_ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);

  ser_state_e       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bitcnt;
  logic             r_ser;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_bit_end;
  logic             w_pre_end;
  logic [WIDTH-1:0] w_shifted;
  logic             w_head;
  logic             w_head_next;

  assign in_ready = (r_state == IDLE) && !rst;
  assign w_accept = in_valid && in_ready;
  assign ser_out  = r_ser;
  assign busy     = r_busy;
  assign done     = r_done;

  // The output end of the shift register is the MSB or LSB depending on order
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted   = r_shift << 1;
      assign w_head      = r_shift[WIDTH-1];
      assign w_head_next = w_shifted[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted   = r_shift >> 1;
      assign w_head      = r_shift[0];
      assign w_head_next = w_shifted[0];
    end
  endgenerate

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_busy),
    .i_clr     (w_accept),
    .o_bit_end (w_bit_end),
    .o_pre_end (w_pre_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_ser    <= LINE_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= in_data;
            r_state <= START;
            r_ser   <= START_BIT;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_ser   <= w_head;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bitcnt == BW'(WIDTH - 1)) begin
              r_state  <= STOP;
              r_ser    <= STOP_BIT;
              r_bitcnt <= '0;
              // A one-cycle stop bit is its own last cycle
              r_done   <= (DIV == 1);
            end else begin
              r_bitcnt <= r_bitcnt + BW'(1);
              r_shift  <= w_shifted;
              r_ser    <= w_head_next;
            end
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state <= IDLE;
            r_ser   <= LINE_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_done <= w_pre_end;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ser   <= LINE_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_word_serializer.sv
// ============================================================================
// tb_shift_word_serializer : scoreboard bench over three parameter variants
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module tb_shift_word_serializer;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic [2:0] valid;
  logic [2:0] rdy;
  logic [2:0] ser;
  logic [2:0] bsy;
  logic [2:0] dn;

  int   total;
  int   bad;
  logic exp_q[$];

  // 0: DIV=1 MSB first, 1: DIV=1 LSB first, 2: DIV=3 MSB first
  shift_word_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid[0]),
    .in_ready(rdy[0]), .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0]));

  shift_word_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid[1]),
    .in_ready(rdy[1]), .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1]));

  shift_word_serializer #(.WIDTH(4), .DIV(3), .MSB_FIRST(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid[2]),
    .in_ready(rdy[2]), .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_frame(input logic [3:0] w, input int div, input bit msb);
    logic b;
    for (int s = 0; s < 6; s++) begin
      if (s == 0)      b = 1'b0;
      else if (s == 5) b = 1'b1;
      else if (msb)    b = w[4-s];
      else             b = w[s-1];
      for (int d = 0; d < div; d++) exp_q.push_back(b);
    end
  endtask

  // Entered and left just after a falling edge
  task automatic run_frame(input int idx, input logic [3:0] w, input int div,
                           input bit msb, input bit hold, input logic [3:0] nxt);
    int   n;
    logic e;
    in_data    = w;
    valid[idx] = 1'b1;
    total++;
    if (rdy[idx] !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_accept dut=%0d got=%b want=1", idx, rdy[idx]);
    end
    push_frame(w, div, msb);
    n = exp_q.size();
    @(posedge clk);
    #1;
    in_data    = nxt;
    valid[idx] = hold;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (ser[idx] !== e) begin
        bad++;
        $display("FAIL ser_out dut=%0d word=%h cyc=%0d got=%b want=%b", idx, w, k + 1, ser[idx], e);
      end
      total++;
      if (bsy[idx] !== 1'b1) begin
        bad++;
        $display("FAIL busy dut=%0d cyc=%0d got=%b want=1", idx, k + 1, bsy[idx]);
      end
      total++;
      if (dn[idx] !== ((k == n - 1) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL done dut=%0d cyc=%0d got=%b want=%b", idx, k + 1, dn[idx], (k == n - 1));
      end
      total++;
      if (rdy[idx] !== 1'b0) begin
        bad++;
        $display("FAIL ready_busy dut=%0d cyc=%0d got=%b want=0", idx, k + 1, rdy[idx]);
      end
    end
    @(negedge clk);
    total++;
    if (bsy[idx] !== 1'b0 || ser[idx] !== 1'b1 || dn[idx] !== 1'b0 || rdy[idx] !== 1'b1) begin
      bad++;
      $display("FAIL post_frame dut=%0d busy/ser/done/rdy got=%b%b%b%b want=0101",
               idx, bsy[idx], ser[idx], dn[idx], rdy[idx]);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    valid   = 3'b111;
    in_data = 4'hF;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (ser[i] !== 1'b1 || bsy[i] !== 1'b0 || dn[i] !== 1'b0 || rdy[i] !== 1'b0) begin
          bad++;
          $display("FAIL reset_state dut=%0d ser/busy/done/rdy got=%b%b%b%b want=1000",
                   i, ser[i], bsy[i], dn[i], rdy[i]);
        end
      end
    end
    rst   = 1'b0;
    valid = 3'b000;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rdy[i] !== 1'b1) begin
        bad++;
        $display("FAIL ready_after_reset dut=%0d got=%b want=1", i, rdy[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_msb_div1();
    run_frame(0, 4'b1011, 1, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic test_lsb_div1();
    run_frame(1, 4'b1011, 1, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_div3();
    run_frame(2, 4'b0110, 3, 1'b1, 1'b0, 4'h9);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 4'hA, 1, 1'b1, 1'b1, 4'h5);
    run_frame(0, 4'h5, 1, 1'b1, 1'b0, 4'h0);
  endtask

  task automatic test_mid_reset();
    logic e;
    in_data  = 4'h3;
    valid[0] = 1'b1;
    push_frame(4'h3, 1, 1'b1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    in_data  = 4'hC;
    // Start bit and data bits 0..2; reset lands while bit 2 is on the line
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (ser[0] !== e || dn[0] !== 1'b0) begin
        bad++;
        $display("FAIL pre_reset_frame cyc=%0d ser/done got=%b%b want=%b0", k + 1, ser[0], dn[0], e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ser[0] !== 1'b1 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset ser/busy/done got=%b%b%b want=100", ser[0], bsy[0], dn[0]);
    end
    exp_q.delete();
    rst = 1'b0;
    #1;
    total++;
    if (rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_mid_reset got=%b want=1", rdy[0]);
    end
    @(negedge clk);
    total++;
    if (dn[0] !== 1'b0 || ser[0] !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_abort done/ser got=%b%b want=01", dn[0], ser[0]);
    end
    run_frame(0, 4'hF, 1, 1'b1, 1'b0, 4'h0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    valid   = 3'b000;
    in_data = 4'h0;
    test_reset();
    test_msb_div1();
    test_lsb_div1();
    test_div3();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_word_serializer.md
Name: shift_word_serializer

Overview:
- Downstream stage of the 4-bit universal shift register.
- Accepts a parallel word (normally the register's PO) over a valid/ready handshake and transmits it on a single serial line.
- Frame format: one start bit (0), WIDTH data bits, one stop bit (1); line idles high.
- Bit period is programmable in clock cycles, so the same block drives both fast on-chip links and slow off-chip pins.

Parameters:
- WIDTH, 4, data bits per frame; legal range 1..32.
- DIV, 1, clock cycles per serial bit; legal range 1..65535.
- MSB_FIRST, 1, 1 = transmit in_data[WIDTH-1] first; 0 = transmit in_data[0] first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to send; sampled only on accept.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial line, registered.
- busy  output  1  frame in progress (START, DATA or STOP state).
- done  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- State machine (registered): IDLE, START, DATA, STOP. Encoding lives in the package.
- Reset values when rst=1 at an edge: state=IDLE, ser_out=1, busy=0, done=0, bit and tick counters=0, data shift register=0.
- in_ready = (state==IDLE) && !rst. This is the only combinational output.
- Accept occurs when in_valid && in_ready at a rising edge:
  - latch in_data into the internal shift register;
  - go to START, set ser_out=0 and busy=1, both visible the following cycle.
- in_data and in_valid are ignored while not in IDLE; changes after accept do not affect the frame.
- Tick counter:
  - counts 0..DIV-1 in every non-IDLE state;
  - a bit ends when tick==DIV-1, at which point tick returns to 0;
  - with DIV=1 every cycle is a bit end.
- START: ser_out=0 for DIV cycles, then DATA with ser_out = first data bit.
- DATA:
  - WIDTH bits, each held for DIV cycles;
  - on each bit end the shift register shifts toward the output end: left if MSB_FIRST, right otherwise;
  - bit counter increments on each bit end; after bit WIDTH-1 ends, go to STOP with ser_out=1.
- STOP: ser_out=1 for DIV cycles.
  - done=1 during the last STOP cycle (tick==DIV-1).
  - Next state is IDLE with busy=0.
- Frame length: exactly (WIDTH+2)*DIV cycles of busy=1 from accept+1.
  - in_ready rises the cycle after busy falls, so back-to-back frames have exactly one idle-high cycle between stop and next start.
- Simultaneous events: none possible while busy, since handshake inputs are masked. rst overrides everything.
- Reset mid-frame: the frame is aborted with no done pulse; ser_out=1 the cycle after the reset edge.
- Counter widths:
  - bit counter: $clog2(WIDTH+1);
  - tick counter: $clog2(DIV+1);
  - no wrap occurs inside a frame.

Decomposition:
- Package shift_ser_pkg holds:
  - the state enum typedef (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - localparams LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, bit_tick_gen: DIV counter with enable (busy) and synchronous clear, outputting bit_end. The FSM and data shift register stay in the top module.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> ser_out=1, busy=0, done=0, in_ready=0; after release in_ready=1.
- WIDTH=4, DIV=1, MSB_FIRST=1, in_data=4'b1011 accepted at cycle 0:
  - ser_out over cycles 1..6 = 0,1,0,1,1,1;
  - done=1 in cycle 6 only;
  - busy=1 for cycles 1..6;
  - in_ready=1 at cycle 7.
- Same word with MSB_FIRST=0 -> ser_out cycles 1..6 = 0,1,1,0,1,1.
- DIV=3, in_data=4'b0110, MSB_FIRST=1:
  - each bit held 3 cycles;
  - busy for 18 cycles;
  - done on cycle 18 only.
- Back-to-back: in_valid held high with words 4'hA then 4'h5 -> exactly one idle-high cycle between frames; in_data change mid-frame does not alter the frame.
- Reset mid-frame: assert rst during DATA bit 2 -> next cycle ser_out=1, busy=0, no done pulse; a new frame with 4'hF then transmits correctly.
